// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC selection for jumps and branches,
// and the IF/ID pipeline register with stall, flush and redirect squashing.
module if_stage #(
  parameter logic [29:0] RESET_PC = 30'h0000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_taken,
  input  logic [29:0] br_off,
  input  logic        jump,
  input  logic [25:0] jump_idx,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_instr,
  output logic [29:0] id_pc1,
  output logic        id_valid,
  output logic [15:0] id_imm
);

  logic [29:0] pc;
  logic [29:0] pc1;
  logic [29:0] br_target;
  logic [29:0] jump_target;
  logic [29:0] next_pc;
  logic        redirect;

  assign imem_addr   = pc;
  assign pc1         = pc + 30'd1;
  assign br_target   = id_pc1 + br_off;
  assign jump_target = {id_pc1[29:26], jump_idx};
  assign id_imm      = id_instr[15:0];

  // A redirect only counts for a real instruction in ID that is not being held.
  assign redirect = (jump | br_taken) & id_valid & ~stall;

  always_comb begin
    next_pc = pc1;
    if (stall)
      next_pc = pc;
    else if (redirect && jump)
      next_pc = jump_target;
    else if (redirect)
      next_pc = br_target;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

  // A redirect squashes the wrong-path fetch; flush wins over stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_instr <= 32'h0;
      id_pc1   <= 30'h0;
      id_valid <= 1'b0;
    end else if (flush || redirect) begin
      id_instr <= 32'h0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_instr <= imem_data;
      id_pc1   <= pc1;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage: reset, sequential fetch, branch,
// jump priority, stall, flush, PC wrap and asynchronous reset.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        br_taken;
  logic [29:0] br_off;
  logic        jump;
  logic [25:0] jump_idx;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] id_instr;
  logic [29:0] id_pc1;
  logic        id_valid;
  logic [15:0] id_imm;

  int checks;
  int errors;

  if_stage #(.RESET_PC(30'h0000000)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .flush     (flush),
    .br_taken  (br_taken),
    .br_off    (br_off),
    .jump      (jump),
    .jump_idx  (jump_idx),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .id_instr  (id_instr),
    .id_pc1    (id_pc1),
    .id_valid  (id_valid),
    .id_imm    (id_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a fixed word at address 0, elsewhere {2'b10, addr}.
  function automatic logic [31:0] mem_word(input logic [29:0] addr);
    if (addr == 30'h0)
      return 32'h2008_0005;
    return {2'b10, addr};
  endfunction

  assign imem_data = mem_word(imem_addr);

  task automatic applyStimulus(input logic st, input logic fl, input logic bt,
                               input logic [29:0] off, input logic jp,
                               input logic [25:0] idx);
    stall    = st;
    flush    = fl;
    br_taken = bt;
    br_off   = off;
    jump     = jp;
    jump_idx = idx;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    assert (actual === expected) else begin
      errors++;
      $error("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [29:0] pc,
                            input logic [31:0] instr, input logic [29:0] pc1,
                            input logic valid);
    checkOutput({tag, ".pc"},    {2'b00, imem_addr}, {2'b00, pc});
    checkOutput({tag, ".instr"}, id_instr, instr);
    checkOutput({tag, ".pc1"},   {2'b00, id_pc1}, {2'b00, pc1});
    checkOutput({tag, ".valid"}, {31'h0, id_valid}, {31'h0, valid});
    checkOutput({tag, ".imm"},   {16'h0, id_imm}, {16'h0, instr[15:0]});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    #2;
    checkState("reset_async", 30'h0, 32'h0, 30'h0, 1'b0);
    step();
    step();
    checkState("reset_held", 30'h0, 32'h0, 30'h0, 1'b0);

    rst_n = 1'b1;
    step();
    checkState("first_fetch", 30'h1, 32'h2008_0005, 30'h1, 1'b1);

    // Branch back by 2 words to reach the top of the address space
    applyStimulus(1'b0, 1'b0, 1'b1, 30'h3FFF_FFFE, 1'b0, 26'h0);
    step();
    checkState("br_to_top", 30'h3FFF_FFFF, 32'h0, 30'h1, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("pc_wrap", 30'h0, 32'hBFFF_FFFF, 30'h0, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b1, 26'h000_000F);
    step();
    checkState("jump_0f", 30'h0F, 32'h0, 30'h0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("fetch_0f", 30'h10, 32'h8000_000F, 30'h10, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 30'h3FFF_FFFC, 1'b0, 26'h0);
    step();
    checkState("br_minus4", 30'h0C, 32'h0, 30'h10, 1'b0);

    // br_taken still high but ID holds a bubble, so it must be ignored
    applyStimulus(1'b0, 1'b0, 1'b1, 30'h0000_0100, 1'b0, 26'h0);
    step();
    checkState("br_on_bubble", 30'h0D, 32'h8000_000C, 30'h0D, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 30'h1FFF_FFF6, 1'b0, 26'h0);
    step();
    checkState("br_far", 30'h2000_0003, 32'h0, 30'h0D, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("fetch_far", 30'h2000_0004, 32'hA000_0003, 30'h2000_0004, 1'b1);

    applyStimulus(1'b0, 1'b0, 1'b1, 30'h0000_0005, 1'b1, 26'h000_0040);
    step();
    checkState("jump_wins", 30'h2000_0040, 32'h0, 30'h2000_0004, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("fetch_40", 30'h2000_0041, 32'hA000_0040, 30'h2000_0041, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b1, 30'h0000_0010, 1'b0, 26'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkState("stall_hold", 30'h2000_0041, 32'hA000_0040, 30'h2000_0041, 1'b1);
    end

    applyStimulus(1'b0, 1'b0, 1'b1, 30'h0000_0010, 1'b0, 26'h0);
    step();
    checkState("br_after_stall", 30'h2000_0051, 32'h0, 30'h2000_0041, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("fetch_51", 30'h2000_0052, 32'hA000_0051, 30'h2000_0052, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("flush_stall", 30'h2000_0052, 32'h0, 30'h2000_0052, 1'b0);

    applyStimulus(1'b0, 1'b1, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("flush_only", 30'h2000_0053, 32'h0, 30'h2000_0052, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    step();
    checkState("fetch_53", 30'h2000_0054, 32'hA000_0053, 30'h2000_0054, 1'b1);

    // Reset pulsed between edges while a stalled redirect is pending
    applyStimulus(1'b1, 1'b0, 1'b1, 30'h0000_0010, 1'b0, 26'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkState("reset_mid", 30'h0, 32'h0, 30'h0, 1'b0);
    step();
    checkState("reset_edge", 30'h0, 32'h0, 30'h0, 1'b0);

    applyStimulus(1'b0, 1'b0, 1'b0, 30'h0, 1'b0, 26'h0);
    rst_n = 1'b1;
    step();
    checkState("refetch", 30'h1, 32'h2008_0005, 30'h1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL provide parameter: RESET_PC, 30'h0000000, word address loaded into the PC on reset.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port: stall  input  1  hazard hold: PC and IF/ID register keep their values.
REQ-005 SHALL have port: flush  input  1  turn the IF/ID register into a bubble at the next edge.
REQ-006 SHALL have port: br_taken  input  1  conditional branch in ID resolved taken.
REQ-007 SHALL have port: br_off  input  30  sign-extended word offset of the branch in ID (signex30 output).
REQ-008 SHALL have port: jump  input  1  J-type jump in ID.
REQ-009 SHALL have port: jump_idx  input  26  word index field of the jump in ID.
REQ-010 SHALL have port: imem_addr  output  30  instruction memory word address; equals PC.
REQ-011 SHALL have port: imem_data  input  32  instruction at imem_addr, combinational read, same cycle.
REQ-012 SHALL have port: id_instr  output  32  IF/ID instruction register.
REQ-013 SHALL have port: id_pc1  output  30  IF/ID register holding fetch PC + 1.
REQ-014 SHALL have port: id_valid  output  1  IF/ID register holds a real instruction.
REQ-015 SHALL have port: id_imm  output  16  id_instr[15:0], combinational, feeds the sign extenders.

Function
REQ-016 SHALL hold a 30-bit PC register; imem_addr = PC at all times.
REQ-017 SHALL compute pc1 = PC + 1 modulo 2^30 (30'h3FFFFFFF + 1 = 30'h0000000).
REQ-018 SHALL compute branch target = id_pc1 + br_off modulo 2^30, two's-complement, no overflow flag.
REQ-019 SHALL compute jump target = {id_pc1[29:26], jump_idx}.
REQ-020 SHALL qualify a redirect as (jump or br_taken) and id_valid and not stall; redirects with id_valid=0 or stall=1 are ignored.
REQ-021 SHALL prioritise next-PC per edge: stall -> PC held; else jump redirect -> jump target; else branch redirect -> branch target; else pc1.
REQ-022 SHALL treat jump and br_taken both high as a jump.
REQ-023 SHALL, on a qualified redirect, load IF/ID with a bubble (id_instr=32'h0, id_valid=0, id_pc1 held), squashing the fall-through fetch: fixed one-cycle penalty.
REQ-024 SHALL, on flush=1, load IF/ID with a bubble regardless of stall; the PC still follows REQ-021.
REQ-025 SHALL, with stall=1 and flush=0, hold id_instr, id_pc1 and id_valid unchanged.
REQ-026 SHALL otherwise load id_instr=imem_data, id_pc1=pc1, id_valid=1.
REQ-027 SHALL have latency of one edge from fetch address to IF/ID; the first instruction after reset reaches ID at the first edge with rst_n high.
REQ-028 SHALL output id_imm = 16'h0000 while a bubble is held.

Reset
REQ-029 SHALL, while rst_n=0, force PC=RESET_PC, id_instr=32'h0, id_pc1=30'h0, id_valid=0 immediately, independent of clk.
REQ-030 SHALL, on reset asserted mid-operation (including during stall or redirect), discard all pending state and apply REQ-029.
REQ-031 SHALL not change state on the edge where rst_n is still low; normal fetching starts at the first rising edge with rst_n=1.

Verification
REQ-032 SHALL cover: reset release, RESET_PC=0, imem returns 32'h2008_0005 at 0 -> after 1 edge id_instr=32'h20080005, id_pc1=1, id_valid=1, imem_addr=1.
REQ-033 SHALL cover: id_pc1=30'h10, br_taken=1, br_off=30'h3FFFFFFC (-4), id_valid=1 -> next edge PC=30'h0C, id_valid=0, id_instr=0, id_imm=0.
REQ-034 SHALL cover: jump=1 and br_taken=1 together, id_pc1=30'h2000_0004, jump_idx=26'h0000040 -> PC=30'h2000_0040.
REQ-035 SHALL cover: stall=1 for 3 edges with br_taken=1 -> PC and IF/ID unchanged for 3 edges; redirect takes effect on the first edge after stall drops.
REQ-036 SHALL cover: PC=30'h3FFFFFFF, no redirect -> next PC=30'h0000000, id_pc1=30'h0000000.
REQ-037 SHALL cover: flush=1 with stall=1 -> IF/ID becomes bubble, PC held; rst_n pulsed low between edges -> outputs hit reset values before the next edge.
